// File: rtl/select_counter_pkg.sv
// Shared definitions for the select-counter family.
//   clog2      : ceiling log2, used to size select buses
//   MODE_WRAP  : count wraps to zero past all-ones
//   MODE_SAT   : count holds at all-ones
//   DEF_*      : default channel width, channel count and prescaler width
package select_counter_pkg;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_NCH   = 4;
  localparam int unsigned DEF_PRE_W = 8;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/select_counter_channel.sv
// One counter channel: prescaler, programmable divisor, count, sticky
// overflow flag and a one-cycle step pulse.
//   Clk, Reset : clock, asynchronous active-high reset
//   hit        : this channel is selected this cycle
//   clr        : synchronous clear of count, prescaler and ovf
//   cfg_we     : load divisor from cfg_div, restart prescaler
//   count      : channel count
//   div        : current divisor
//   ovf        : sticky overflow / saturation flag
//   tick       : count step fired on the previous edge
module select_counter_channel
  import select_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned PRE_W    = DEF_PRE_W,
  parameter bit          SATURATE = MODE_WRAP
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             hit,
  input  logic             clr,
  input  logic             cfg_we,
  input  logic [PRE_W-1:0] cfg_div,
  output logic [WIDTH-1:0] count,
  output logic [PRE_W-1:0] div,
  output logic             ovf,
  output logic             tick
);

  logic [PRE_W-1:0] pre;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
      pre   <= '0;
      div   <= '0;
      ovf   <= 1'b0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      // Divisor load is independent of clear; both may land together.
      if (cfg_we) begin
        div <= cfg_div;
        pre <= '0;
      end
      if (clr) begin
        count <= '0;
        pre   <= '0;
        ovf   <= 1'b0;
      end else if (hit && !cfg_we) begin
        if (pre == div) begin
          pre  <= '0;
          tick <= 1'b1;
          if (count == '1) begin
            ovf <= 1'b1;
            if (SATURATE != MODE_SAT) count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_select_counter.sv
// N-channel event counter. Slt routes each enabled clock to one channel;
// each channel prescales, counts and flags overflow independently.
//   Clk, Reset : clock, asynchronous active-high reset
//   En, Slt    : count enable and channel select (Slt >= NCH hits nothing)
//   Clr        : per-channel synchronous clear
//   Cfg_We/Ch/Div : divisor write (Cfg_Ch >= NCH ignored)
//   Count      : channel c at [c*WIDTH +: WIDTH]
//   Ovf, Tick  : per-channel sticky overflow and step pulse
//   Div        : channel c divisor at [c*PRE_W +: PRE_W]
module multi_select_counter
  import select_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned NCH      = DEF_NCH,
  parameter int unsigned SELW     = clog2(NCH),
  parameter int unsigned PRE_W    = DEF_PRE_W,
  parameter bit          SATURATE = MODE_WRAP
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 En,
  input  logic [SELW-1:0]      Slt,
  input  logic [NCH-1:0]       Clr,
  input  logic                 Cfg_We,
  input  logic [SELW-1:0]      Cfg_Ch,
  input  logic [PRE_W-1:0]     Cfg_Div,
  output logic [NCH*WIDTH-1:0] Count,
  output logic [NCH-1:0]       Ovf,
  output logic [NCH-1:0]       Tick,
  output logic [NCH*PRE_W-1:0] Div
);

  logic [NCH-1:0] hit_vec;
  logic [NCH-1:0] cfg_vec;

  // Out-of-range selects simply match no channel.
  always_comb begin
    hit_vec = '0;
    cfg_vec = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      hit_vec[c] = En && (32'(Slt) == c);
      cfg_vec[c] = Cfg_We && (32'(Cfg_Ch) == c);
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    select_counter_channel #(
      .WIDTH   (WIDTH),
      .PRE_W   (PRE_W),
      .SATURATE(SATURATE)
    ) u_ch (
      .Clk    (Clk),
      .Reset  (Reset),
      .hit    (hit_vec[c]),
      .clr    (Clr[c]),
      .cfg_we (cfg_vec[c]),
      .cfg_div(Cfg_Div),
      .count  (Count[c*WIDTH +: WIDTH]),
      .div    (Div[c*PRE_W +: PRE_W]),
      .ovf    (Ovf[c]),
      .tick   (Tick[c])
    );
  end

endmodule

// File: tb/tb_multi_select_counter.sv
module tb_multi_select_counter;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = 3;
  localparam int unsigned PW = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          En;
  logic [SW-1:0] Slt;
  logic [N-1:0]  Clr;
  logic          Cfg_We;
  logic [SW-1:0] Cfg_Ch;
  logic [PW-1:0] Cfg_Div;

  logic [N*W-1:0]  cnt_w, cnt_s;
  logic [N-1:0]    ovf_w, ovf_s, tick_w, tick_s;
  logic [N*PW-1:0] div_w, div_s;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  multi_select_counter #(
    .WIDTH(W), .NCH(N), .SELW(SW), .PRE_W(PW), .SATURATE(1'b0)
  ) dut_wrap (
    .Clk(Clk), .Reset(Reset), .En(En), .Slt(Slt), .Clr(Clr),
    .Cfg_We(Cfg_We), .Cfg_Ch(Cfg_Ch), .Cfg_Div(Cfg_Div),
    .Count(cnt_w), .Ovf(ovf_w), .Tick(tick_w), .Div(div_w)
  );

  multi_select_counter #(
    .WIDTH(W), .NCH(N), .SELW(SW), .PRE_W(PW), .SATURATE(1'b1)
  ) dut_sat (
    .Clk(Clk), .Reset(Reset), .En(En), .Slt(Slt), .Clr(Clr),
    .Cfg_We(Cfg_We), .Cfg_Ch(Cfg_Ch), .Cfg_Div(Cfg_Div),
    .Count(cnt_s), .Ovf(ovf_s), .Tick(tick_s), .Div(div_s)
  );

  // Reference model state
  logic [W-1:0]  m_cw[N], m_cs[N];
  logic [PW-1:0] m_pre[N], m_div[N];
  logic          m_ow[N], m_os[N], m_tk[N];

  typedef struct {
    logic [N*W-1:0]  cw, cs;
    logic [N-1:0]    ow, os, tk;
    logic [N*PW-1:0] dv;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int unsigned c = 0; c < N; c++) begin
      m_cw[c] = '0; m_cs[c] = '0; m_pre[c] = '0; m_div[c] = '0;
      m_ow[c] = 1'b0; m_os[c] = 1'b0; m_tk[c] = 1'b0;
    end
  endtask

  task automatic model_step(input logic en, input logic [SW-1:0] slt, input logic [N-1:0] clr,
                            input logic we, input logic [SW-1:0] ch, input logic [PW-1:0] dv);
    for (int unsigned c = 0; c < N; c++) begin
      logic hit, cfg;
      hit = en && (32'(slt) == c);
      cfg = we && (32'(ch) == c);
      m_tk[c] = 1'b0;
      if (cfg) m_div[c] = dv;
      if (clr[c]) begin
        m_cw[c] = '0; m_cs[c] = '0; m_pre[c] = '0; m_ow[c] = 1'b0; m_os[c] = 1'b0;
      end else if (cfg) begin
        m_pre[c] = '0;
      end else if (hit) begin
        if (m_pre[c] == m_div[c]) begin
          m_pre[c] = '0;
          m_tk[c]  = 1'b1;
          if (m_cw[c] == 8'hFF) begin m_cw[c] = 8'h00; m_ow[c] = 1'b1; end
          else m_cw[c] = m_cw[c] + 8'd1;
          if (m_cs[c] == 8'hFF) m_os[c] = 1'b1;
          else m_cs[c] = m_cs[c] + 8'd1;
        end else begin
          m_pre[c] = m_pre[c] + 8'd1;
        end
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int unsigned c = 0; c < N; c++) begin
      e.cw[c*W +: W]   = m_cw[c];
      e.cs[c*W +: W]   = m_cs[c];
      e.dv[c*PW +: PW] = m_div[c];
      e.ow[c] = m_ow[c];
      e.os[c] = m_os[c];
      e.tk[c] = m_tk[c];
    end
    sbq.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    if (sbq.size() == 0) begin
      check("sb_empty", 64'(1), 64'(0));
      return;
    end
    e = sbq.pop_front();
    check("count_wrap", 64'(cnt_w),  64'(e.cw));
    check("count_sat",  64'(cnt_s),  64'(e.cs));
    check("ovf_wrap",   64'(ovf_w),  64'(e.ow));
    check("ovf_sat",    64'(ovf_s),  64'(e.os));
    check("tick_wrap",  64'(tick_w), 64'(e.tk));
    check("tick_sat",   64'(tick_s), 64'(e.tk));
    check("div_wrap",   64'(div_w),  64'(e.dv));
    check("div_sat",    64'(div_s),  64'(e.dv));
  endtask

  task automatic step(input logic en, input logic [SW-1:0] slt, input logic [N-1:0] clr,
                      input logic we, input logic [SW-1:0] ch, input logic [PW-1:0] dv);
    En = en; Slt = slt; Clr = clr; Cfg_We = we; Cfg_Ch = ch; Cfg_Div = dv;
    model_step(en, slt, clr, we, ch, dv);
    push_expected();
    @(posedge Clk);
    #1;
    compare_head();
  endtask

  task automatic hits(input logic [SW-1:0] slt, input int n);
    for (int i = 0; i < n; i++) step(1'b1, slt, '0, 1'b0, '0, '0);
  endtask

  initial begin
    Reset = 1'b1; En = 1'b0; Slt = '0; Clr = '0; Cfg_We = 1'b0; Cfg_Ch = '0; Cfg_Div = '0;
    model_reset();
    #3;
    check("reset_count", 64'(cnt_w), 64'(0));
    check("reset_ovf",   64'(ovf_s), 64'(0));
    check("reset_tick",  64'(tick_w), 64'(0));
    check("reset_div",   64'(div_w), 64'(0));
    @(posedge Clk); #1;
    Reset = 1'b0;

    // Channel 0, divisor 0: every hit steps
    hits(3'd0, 5);
    check("ch0_five", 64'(cnt_w[0 +: W]), 64'(5));
    step(1'b0, 3'd0, '0, 1'b0, '0, '0);

    // Channel 1, divisor 3: steps on 4th and 8th hits
    step(1'b0, 3'd0, '0, 1'b1, 3'd1, 8'd3);
    hits(3'd1, 8);
    check("ch1_div3",  64'(cnt_w[1*W +: W]), 64'(2));
    check("ch0_hold",  64'(cnt_w[0 +: W]),   64'(5));

    // Channel 2 through all-ones in both modes
    hits(3'd2, 254);
    check("ch2_fe", 64'(cnt_w[2*W +: W]), 64'(8'hFE));
    hits(3'd2, 3);
    check("ch2_wrap_cnt", 64'(cnt_w[2*W +: W]), 64'(8'h01));
    check("ch2_wrap_ovf", 64'(ovf_w[2]), 64'(1));
    check("ch2_sat_cnt",  64'(cnt_s[2*W +: W]), 64'(8'hFF));
    check("ch2_sat_ovf",  64'(ovf_s[2]), 64'(1));

    // Clear with concurrent hit; divisor survives
    step(1'b0, 3'd0, '0, 1'b1, 3'd2, 8'd5);
    step(1'b1, 3'd2, 4'b0100, 1'b0, '0, '0);
    check("ch2_clr_cnt",  64'(cnt_s[2*W +: W]), 64'(0));
    check("ch2_clr_ovf",  64'(ovf_w[2]), 64'(0));
    check("ch2_clr_tick", 64'(tick_s[2]), 64'(0));
    check("ch2_clr_div",  64'(div_w[2*PW +: PW]), 64'(5));

    // Out-of-range select and out-of-range config address
    step(1'b1, 3'd7, '0, 1'b0, '0, '0);
    step(1'b0, 3'd0, '0, 1'b1, 3'd5, 8'd9);

    // Channel 3: config write discards a concurrent hit
    step(1'b0, 3'd0, '0, 1'b1, 3'd3, 8'd2);
    hits(3'd3, 2);
    step(1'b1, 3'd3, '0, 1'b1, 3'd3, 8'd1);
    check("ch3_cfg_nostep", 64'(cnt_w[3*W +: W]), 64'(0));
    hits(3'd3, 2);
    check("ch3_after_cfg", 64'(cnt_w[3*W +: W]), 64'(1));

    // Clear and config on the same channel both take effect
    step(1'b1, 3'd3, 4'b1000, 1'b1, 3'd3, 8'd4);
    check("ch3_clr_cfg_div", 64'(div_s[3*PW +: PW]), 64'(4));
    check("ch3_clr_cfg_cnt", 64'(cnt_s[3*W +: W]), 64'(0));

    // Asynchronous reset mid-prescale on channel 1 (Div1=3, pre reaches 2)
    hits(3'd1, 2);
    #2;
    Reset = 1'b1;
    #1;
    check("async_count_w", 64'(cnt_w), 64'(0));
    check("async_count_s", 64'(cnt_s), 64'(0));
    check("async_ovf",     64'(ovf_w | ovf_s), 64'(0));
    check("async_tick",    64'(tick_w | tick_s), 64'(0));
    check("async_div",     64'(div_w | div_s), 64'(0));
    model_reset();
    Reset = 1'b0;
    hits(3'd1, 4);
    check("ch1_post_reset", 64'(cnt_w[1*W +: W]), 64'(4));
    check("sb_drained", 64'(sbq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
